// File: rtl/fifo_flops_mc_rr.sv
// rtl/fifo_flops_mc_rr.sv - multi-channel flop FIFO drained through one round-robin FWFT port
module fifo_flops_mc_rr #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16,
    parameter int BITS     = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    localparam int CW      = $clog2(DEPTH) + 1,
    localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS-1:0]      push,
    input  logic [CHANNELS*BITS-1:0] Din,
    input  logic                     pop,
    input  logic                     clr_err,
    output logic [BITS-1:0]          Dout,
    output logic [SW-1:0]            Dout_ch,
    output logic                     pndng,
    output logic [CHANNELS-1:0]      full,
    output logic [CHANNELS-1:0]      almost_full,
    output logic [CHANNELS*CW-1:0]   count,
    output logic [CHANNELS-1:0]      overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);

    logic [BITS-1:0]     mem   [CHANNELS][DEPTH];
    logic [PW-1:0]       wrptr [CHANNELS];
    logic [PW-1:0]       rdptr [CHANNELS];
    logic [CW-1:0]       cnt   [CHANNELS];
    logic [SW-1:0]       rr_ptr;
    logic [SW-1:0]       sel;
    logic [SW-1:0]       rr_next;
    logic [SW:0]         idx;
    logic                found;
    logic                pop_ok;
    logic [CHANNELS-1:0] nonempty;
    logic [CHANNELS-1:0] pop_ch;
    logic [CHANNELS-1:0] push_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Per-channel flag decodes straight from the count registers.
    always_comb begin
        count       = '0;
        nonempty    = '0;
        full        = '0;
        almost_full = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            nonempty[c]        = (cnt[c] != '0);
            full[c]            = (cnt[c] == CW'(DEPTH));
            almost_full[c]     = (cnt[c] >= CW'(AF_LEVEL));
            count[c*CW +: CW]  = cnt[c];
        end
    end

    // Round-robin search: first non-empty channel starting at rr_ptr.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = {1'b0, rr_ptr} + (SW+1)'(i);
            if (idx >= (SW+1)'(CHANNELS)) begin
                idx = idx - (SW+1)'(CHANNELS);
            end
            if (!found && nonempty[idx[SW-1:0]]) begin
                sel   = idx[SW-1:0];
                found = 1'b1;
            end
        end
    end

    // Output port, accepted-pop and accepted-push decode.
    always_comb begin
        pndng   = |nonempty;
        Dout    = pndng ? mem[sel][rdptr[sel]] : '0;
        Dout_ch = sel;
        rr_next = (sel == SW'(CHANNELS - 1)) ? '0 : sel + 1'b1;
        pop_ok  = pop & pndng;
        pop_ch  = '0;
        push_ok = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pop_ch[c]  = pop_ok && (sel == SW'(c));
            // A full channel still accepts a push when its head is popped in the same cycle.
            push_ok[c] = push[c] && ((cnt[c] != CW'(DEPTH)) || pop_ch[c]);
        end
    end

    // Pointer, count, arbiter and sticky-error state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr    <= '0;
            underflow <= 1'b0;
            overflow  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                wrptr[c] <= '0;
                rdptr[c] <= '0;
                cnt[c]   <= '0;
            end
        end else begin
            if (pop_ok) begin
                rr_ptr <= rr_next;
            end
            underflow <= (underflow & ~clr_err) | (pop & ~pndng);
            for (int c = 0; c < CHANNELS; c++) begin
                if (push_ok[c]) begin
                    wrptr[c] <= ptr_inc(wrptr[c]);
                end
                if (pop_ch[c]) begin
                    rdptr[c] <= ptr_inc(rdptr[c]);
                end
                if (push_ok[c] && !pop_ch[c]) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end else if (!push_ok[c] && pop_ch[c]) begin
                    cnt[c] <= cnt[c] - 1'b1;
                end
                overflow[c] <= (overflow[c] & ~clr_err) | (push[c] & ~push_ok[c]);
            end
        end
    end

    // Storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (push_ok[c]) begin
                    mem[c][wrptr[c]] <= Din[c*BITS +: BITS];
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_flops_mc_rr.sv
// tb/tb_fifo_flops_mc_rr.sv - directed self-checking bench with queue-based reference model
module tb_fifo_flops_mc_rr;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 channels x 16 words x 32 bits
    logic         rst_a = 1'b0;
    logic [3:0]   push_a = '0;
    logic [127:0] din_a = '0;
    logic         pop_a = 1'b0, clr_a = 1'b0;
    logic [31:0]  dout_a;
    logic [1:0]   dch_a;
    logic         pndng_a, udf_a;
    logic [3:0]   full_a, af_a, ovf_a;
    logic [19:0]  cnt_a;

    // Instance B: 2 channels x 5 words x 16 bits
    logic         rst_b = 1'b0;
    logic [1:0]   push_b = '0;
    logic [31:0]  din_b = '0;
    logic         pop_b = 1'b0, clr_b = 1'b0;
    logic [15:0]  dout_b;
    logic [0:0]   dch_b;
    logic         pndng_b, udf_b;
    logic [1:0]   full_b, af_b, ovf_b;
    logic [7:0]   cnt_b;

    fifo_flops_mc_rr u_a (
        .clk(clk), .rst(rst_a), .push(push_a), .Din(din_a), .pop(pop_a), .clr_err(clr_a),
        .Dout(dout_a), .Dout_ch(dch_a), .pndng(pndng_a), .full(full_a), .almost_full(af_a),
        .count(cnt_a), .overflow(ovf_a), .underflow(udf_a)
    );

    fifo_flops_mc_rr #(.CHANNELS(2), .DEPTH(5), .BITS(16)) u_b (
        .clk(clk), .rst(rst_b), .push(push_b), .Din(din_b), .pop(pop_b), .clr_err(clr_b),
        .Dout(dout_b), .Dout_ch(dch_b), .pndng(pndng_b), .full(full_b), .almost_full(af_b),
        .count(cnt_b), .overflow(ovf_b), .underflow(udf_b)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel, index k*4+c for instance k.
    typedef logic [31:0] wq_t [$];
    wq_t        mq [8];
    int         mrr [2];
    logic [3:0] movf [2];
    logic       mudf [2];

    function automatic int msel(input int k, input int nch);
        int c;
        for (int i = 0; i < nch; i++) begin
            c = (mrr[k] + i) % nch;
            if (mq[k*4+c].size() > 0) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input int k, input int nch, input int dep, input int bits,
                              input logic rst_i, input logic [3:0] push_i, input logic [127:0] din_i,
                              input logic pop_i, input logic clr_i);
        int s;
        logic [3:0] ovf_ev;
        logic udf_ev;
        logic [31:0] w;
        if (!rst_i) begin
            for (int c = 0; c < 4; c++) mq[k*4+c].delete();
            mrr[k]  = 0;
            movf[k] = '0;
            mudf[k] = 1'b0;
            return;
        end
        s = msel(k, nch);
        ovf_ev = '0;
        udf_ev = 1'b0;
        if (pop_i) begin
            if (s >= 0) begin
                void'(mq[k*4+s].pop_front());
                mrr[k] = (s + 1) % nch;
            end else begin
                udf_ev = 1'b1;
            end
        end
        for (int c = 0; c < nch; c++) begin
            if (push_i[c]) begin
                w = 32'(din_i >> (c * bits));
                if (bits == 16) w = w & 32'h0000_FFFF;
                if (mq[k*4+c].size() < dep) mq[k*4+c].push_back(w);
                else ovf_ev[c] = 1'b1;
            end
        end
        if (clr_i) begin
            movf[k] = '0;
            mudf[k] = 1'b0;
        end
        movf[k] = movf[k] | ovf_ev;
        if (udf_ev) mudf[k] = 1'b1;
    endtask

    always @(posedge clk) begin
        model_step(0, 4, 16, 32, rst_a, push_a, din_a, pop_a, clr_a);
        model_step(1, 2, 5, 16, rst_b, {2'b00, push_b}, {96'b0, din_b}, pop_b, clr_b);
    end

    task automatic compare_inst(input int k);
        int nch, dep, s, sz;
        logic [31:0] ed, ad, ach;
        logic ap, au;
        logic [3:0] afu, aaf, aov;
        logic [4:0] acnt;
        string p;
        nch = (k == 0) ? 4 : 2;
        dep = (k == 0) ? 16 : 5;
        s   = msel(k, nch);
        ed  = (s >= 0) ? mq[k*4+s][0] : 32'h0;
        if (k == 0) begin
            p = "a"; ap = pndng_a; ad = dout_a; ach = 32'(dch_a);
            afu = full_a; aaf = af_a; aov = ovf_a; au = udf_a;
        end else begin
            p = "b"; ap = pndng_b; ad = 32'(dout_b); ach = 32'(dch_b);
            afu = {2'b00, full_b}; aaf = {2'b00, af_b}; aov = {2'b00, ovf_b}; au = udf_b;
        end
        check({p, ".pndng"}, 32'(ap), 32'(s >= 0));
        check({p, ".Dout"}, ad, ed);
        check({p, ".Dout_ch"}, ach, (s >= 0) ? 32'(s) : 32'h0);
        check({p, ".underflow"}, 32'(au), 32'(mudf[k]));
        for (int c = 0; c < nch; c++) begin
            sz   = mq[k*4+c].size();
            acnt = (k == 0) ? cnt_a[c*5 +: 5] : {1'b0, cnt_b[c*4 +: 4]};
            check($sformatf("%s.count[%0d]", p, c), 32'(acnt), 32'(sz));
            check($sformatf("%s.full[%0d]", p, c), 32'(afu[c]), 32'(sz == dep));
            check($sformatf("%s.almost_full[%0d]", p, c), 32'(aaf[c]), 32'(sz >= dep - 2));
            check($sformatf("%s.overflow[%0d]", p, c), 32'(aov[c]), 32'(movf[k][c]));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare_inst(0);
            compare_inst(1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int seq [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        // Reset held with traffic on every input
        push_a = 4'hF; din_a = {4{32'hDEAD_BEEF}}; pop_a = 1'b1;
        push_b = 2'b11; din_b = 32'h1234_5678; pop_b = 1'b1;
        step(); chk_en = 1'b1; step(); step();
        rst_a = 1'b1; rst_b = 1'b1; push_a = '0; pop_a = 1'b0; push_b = '0; pop_b = 1'b0;
        step();
        check("rst.pndng", 32'(pndng_a), 32'h0);
        check("rst.Dout", dout_a, 32'h0);
        check("rst.count", 32'(cnt_a), 32'h0);
        check("rst.overflow", 32'(ovf_a), 32'h0);

        // Fill channel 2 past full
        for (int i = 0; i < 17; i++) begin
            push_a = 4'b0100; din_a[64 +: 32] = 32'h100 + 32'(i);
            step();
            if (i == 12) check("fill.af13", 32'(af_a[2]), 32'h0);
            if (i == 13) check("fill.af14", 32'(af_a[2]), 32'h1);
            if (i == 14) check("fill.full15", 32'(full_a[2]), 32'h0);
            if (i == 15) check("fill.full16", 32'(full_a[2]), 32'h1);
        end
        push_a = '0;
        check("fill.count", 32'(cnt_a[10 +: 5]), 32'd16);
        check("fill.overflow", 32'(ovf_a[2]), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check("drain.Dout", dout_a, 32'h100 + 32'(i));
            check("drain.ch", 32'(dch_a), 32'd2);
            pop_a = 1'b1;
            step();
        end
        pop_a = 1'b0;
        check("drain.pndng", 32'(pndng_a), 32'h0);
        clr_a = 1'b1; step(); clr_a = 1'b0;
        check("clr.overflow", 32'(ovf_a), 32'h0);

        // Push and pop together on a full channel
        for (int i = 0; i < 16; i++) begin
            push_a = 4'b0001; din_a[0 +: 32] = 32'h200 + 32'(i);
            step();
        end
        din_a[0 +: 32] = 32'hAA; pop_a = 1'b1;
        step();
        push_a = '0;
        check("pp.count", 32'(cnt_a[0 +: 5]), 32'd16);
        check("pp.overflow", 32'(ovf_a[0]), 32'h0);
        for (int i = 0; i < 16; i++) begin
            check("pp.Dout", dout_a, (i < 15) ? 32'h201 + 32'(i) : 32'hAA);
            step();
        end
        pop_a = 1'b0;
        check("pp.pndng", 32'(pndng_a), 32'h0);

        // Round-robin over channels 0,1,3 from a fresh arbiter
        rst_a = 1'b0; step(); rst_a = 1'b1;
        for (int j = 0; j < 2; j++) begin
            push_a = 4'b1011;
            for (int c = 0; c < 4; c++) din_a[c*32 +: 32] = 32'h300 + 32'(c * 16 + j);
            step();
        end
        push_a = '0;
        for (int i = 0; i < 6; i++) begin
            check("rr.ch", 32'(dch_a), 32'(seq[i]));
            check("rr.Dout", dout_a, 32'h300 + 32'(seq[i] * 16 + i / 3));
            pop_a = 1'b1;
            step();
        end
        pop_a = 1'b0;
        check("rr.pndng", 32'(pndng_a), 32'h0);

        // Underflow and clr_err priority
        pop_a = 1'b1; step();
        check("udf.set", 32'(udf_a), 32'h1);
        check("udf.count", 32'(cnt_a), 32'h0);
        clr_a = 1'b1; step();
        check("udf.clr_vs_err", 32'(udf_a), 32'h1);
        pop_a = 1'b0; step();
        check("udf.clr", 32'(udf_a), 32'h0);
        clr_a = 1'b0;

        // DEPTH=5 pointer wrap on channel 1
        for (int i = 0; i < 23; i++) begin
            push_b = 2'b10; din_b[16 +: 16] = 16'h500 + 16'(i);
            pop_b = (i >= 2);
            if (i >= 2) begin
                check("wrap.Dout", 32'(dout_b), 32'h500 + 32'(i - 2));
                check("wrap.ch", 32'(dch_b), 32'd1);
            end
            step();
        end
        pop_b = 1'b0;
        din_b[16 +: 16] = 16'h517; step();
        push_b = '0;
        check("wrap.count3", 32'(cnt_b[4 +: 4]), 32'd3);
        rst_b = 1'b0; step(); rst_b = 1'b1;
        check("midrst.count", 32'(cnt_b), 32'h0);
        check("midrst.pndng", 32'(pndng_b), 32'h0);
        push_b = 2'b10; din_b[16 +: 16] = 16'h777; step(); push_b = '0;
        check("postrst.Dout", 32'(dout_b), 32'h777);
        check("postrst.count", 32'(cnt_b[4 +: 4]), 32'd1);

        // Overflow raised in the same cycle as clr_err stays set
        for (int i = 0; i < 5; i++) begin
            push_b = 2'b01; din_b[0 +: 16] = 16'h600 + 16'(i);
            step();
        end
        check("b.full0", 32'(full_b[0]), 32'h1);
        clr_b = 1'b1; step();
        check("b.ovf_vs_clr", 32'(ovf_b[0]), 32'h1);
        push_b = '0; step();
        check("b.ovf_clr", 32'(ovf_b[0]), 32'h0);
        clr_b = 1'b0;

        step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_flops_mc_rr.md
# fifo_flops_mc_rr

Multi-channel flop-based FIFO for the mesh router ports: CHANNELS independent circular buffers, each with its own push, full/almost-full and occupancy count, drained through one shared first-word-fall-through output port selected by a round-robin arbiter. It generalises the single-channel no-full FIFO with these additions:
- channel count
- full and almost-full flags
- drop-on-full with sticky overflow reporting
- underflow detection
- arbitrated draining

It sits between the per-terminal inputs and the router's switching logic.

## Interface
- CHANNELS, 4, number of independent FIFOs (>=1)
- DEPTH, 16, words per channel (>=2, power of two not required)
- BITS, 32, data word width
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- CW = $clog2(DEPTH)+1 (count width); SW = max(1,$clog2(CHANNELS)) (channel-id width), derived, not overridable

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- push  in  CHANNELS  per-channel write strobe
- Din  in  CHANNELS*BITS  per-channel write data, channel c at [c*BITS +: BITS]
- pop  in  1  consume word currently on Dout
- clr_err  in  1  clears overflow and underflow sticky flags
- Dout  out  BITS  head word of selected channel, 0 when pndng=0
- Dout_ch  out  SW  channel index of Dout, 0 when pndng=0
- pndng  out  1  at least one channel non-empty
- full  out  CHANNELS  count==DEPTH per channel
- almost_full  out  CHANNELS  count>=AF_LEVEL per channel
- count  out  CHANNELS*CW  per-channel occupancy, channel c at [c*CW +: CW]
- overflow  out  CHANNELS  sticky: push dropped on full channel
- underflow  out  1  sticky: pop while pndng=0

## Operation
- Per channel: write pointer, read pointer (0..DEPTH-1, wrap DEPTH-1 -> 0 explicitly, no reliance on power-of-two wrap), count register 0..DEPTH.
- Arbiter: register rr_ptr (0..CHANNELS-1). sel = first non-empty channel searching rr_ptr, rr_ptr+1, ... modulo CHANNELS. Combinational from registered state.
- Dout = mem[sel][rdptr[sel]], Dout_ch = sel, pndng = OR of (count!=0). When all channels are empty, Dout=0 and Dout_ch=0 (forced, not stale memory).
- Accepted pop (pop && pndng): rdptr[sel]++, count[sel]--, rr_ptr <= (sel+1) mod CHANNELS.
- pop with pndng=0: no state change, underflow <= 1.
- Push on channel c:
  - count[c] < DEPTH: write Din[c] at wrptr[c], wrptr[c]++, count[c]++.
  - count[c] == DEPTH and channel not being popped this cycle: word dropped, pointers/count stable, overflow[c] <= 1.
- Simultaneous push and accepted pop on the same channel: both performed, count unchanged. Applies at full, where no overflow is raised and the write slot is the one freed by the pop (wrptr == rdptr before the update).
- Pushes on different channels in the same cycle are independent and all accepted subject to their own full state.
- clr_err: overflow and underflow <= 0. An error event in the same cycle wins, so the flag stays set.
- Reset (rst=0 at edge):
  - all counts, pointers and rr_ptr <= 0
  - overflow and underflow <= 0
  - push, pop and clr_err ignored
  - memory contents not reset
  - outputs after reset: pndng=0, Dout=0, Dout_ch=0, full=0, almost_full=0, count=0, overflow=0, underflow=0
- Reset mid-traffic discards all stored words. The first push after release behaves as into an empty FIFO.

## Timing
- Push to visibility: word pushed at edge N is countable and poppable from cycle N+1. pndng, full, almost_full and count all update at edge N.
- Pop to next word: Dout/Dout_ch reflect the new selection in the cycle after an accepted pop (combinational from updated pointers).
- full, almost_full and pndng are combinational decodes of count registers, with no extra cycle lag.
- Zero-cycle fall-through: Dout is valid in the same cycle pndng=1; the consumer samples Dout and asserts pop in that cycle.
- Throughput: one pop per cycle total; one push per cycle per channel.

## Test plan
- Reset: drive pushes on all channels with rst=0 for 3 cycles, release -> pndng=0, Dout=0, all count=0, overflow=0.
- Fill/overflow: CHANNELS=4, DEPTH=16; push 17 words 0x100..0x110 on channel 2, no pop:
  - full[2]=1 after the 16th push; almost_full[2]=1 after the 14th
  - the 17th push is dropped, count stays 16, overflow[2]=1
  - draining yields 0x100..0x10F in order
- Push+pop at full: channel 0 full, push 0xAA while popping channel 0 -> count stays 16, overflow[0]=0, 0xAA emerges 16 pops later.
- Round-robin: 2 words each in channels 0,1,3, pop every cycle -> Dout_ch sequence 0,1,3,0,1,3, then pndng=0.
- Underflow/clr_err: pop while empty -> underflow=1, counts unchanged. clr_err together with another empty pop -> underflow stays 1; clr_err alone -> 0.
- Wrap and mid-run reset: DEPTH=5, interleave 23 pushes/pops on channel 1 -> data order preserved across pointer wrap. rst=0 with count=3 -> count=0, pndng=0 next cycle.
